alu_mdu_sequencer: RTL and testbench

Iterative multiply/divide controller that computes RV32M MUL, DIVU and REMU by sequencing the shared 32-bit integer ALU over multiple cycles. It drives the ALU's operands and 4-bit select, and registers the ALU result. A valid/ready request/response handshake lets the execute stage issue one operation and stall until the result returns. The parent instantiates the ALU and muxes its inputs between this block and the normal execute path.

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/alu_mdu_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_alu_mdu_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer: ALU select
// codes (also used by the instruction decoder), operation and state enums.
package mdu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SLL   = 4'b0001;
    localparam logic [3:0] ALU_SLTU  = 4'b0011;
    localparam logic [3:0] ALU_SUB   = 4'b1100;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    typedef enum logic [1:0] {
        MUL  = 2'b00,
        DIVU = 2'b01,
        REMU = 2'b10,
        RSVD = 2'b11
    } mdu_op_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MUL_ADD   = 3'd1,
        MUL_SHIFT = 3'd2,
        DIV_CMP   = 3'd3,
        DIV_SUB   = 3'd4,
        DONE      = 3'd5
    } mdu_state_e;

endpackage

// File: rtl/alu_mdu_sequencer.sv
// Iterative RV32M MUL/DIVU/REMU controller. Borrows the external 32-bit ALU
// while busy: shift-and-add multiply and restoring divide, one ALU operation
// per cycle, result returned over a valid/ready handshake.
module alu_mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      req_op_i,
    input  logic [XLEN-1:0] req_a_i,
    input  logic [XLEN-1:0] req_b_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_data_o,
    output logic            busy_o,
    output logic [XLEN-1:0] alu_a_o,
    output logic [XLEN-1:0] alu_b_o,
    output logic [3:0]      alu_sel_o,
    input  logic [XLEN-1:0] alu_res_i
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    mdu_state_e      r_state;
    mdu_op_e         r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_div;
    logic            r_ge;          // shifted partial remainder >= divisor
    logic            r_resp_valid;
    logic [XLEN-1:0] r_resp_data;

    logic [XLEN-1:0] w_t;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;
    logic            w_last;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign w_t       = {r_rem[XLEN-2:0], r_quo[XLEN-1]};
    assign w_rem_nxt = r_ge ? alu_res_i : r_rem;
    assign w_quo_nxt = {r_quo[XLEN-1:1], r_ge};
    assign w_last    = (r_cnt == LAST_CNT);

    assign req_ready_o  = (r_state == IDLE);
    assign busy_o       = (r_state != IDLE);
    assign resp_valid_o = r_resp_valid;
    assign resp_data_o  = r_resp_data;

    // ALU operand/select steering for the current compute step.
    always_comb begin
        alu_a_o   = '0;
        alu_b_o   = '0;
        alu_sel_o = ALU_ADD;
        case (r_state)
            MUL_ADD: begin
                alu_a_o   = r_acc;
                alu_b_o   = r_mcand;
                alu_sel_o = ALU_ADD;
            end
            MUL_SHIFT: begin
                alu_a_o   = r_mcand;
                alu_b_o   = XLEN'(1);
                alu_sel_o = ALU_SLL;
            end
            DIV_CMP: begin
                alu_a_o   = w_t;
                alu_b_o   = r_div;
                alu_sel_o = ALU_SLTU;
            end
            DIV_SUB: begin
                alu_a_o   = r_rem;
                alu_b_o   = r_div;
                alu_sel_o = ALU_SUB;
            end
            default: begin
                alu_a_o   = '0;
                alu_b_o   = '0;
                alu_sel_o = ALU_ADD;
            end
        endcase
    end

    // Sequencer state machine with all datapath and response registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_op         <= MUL;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_rem        <= '0;
            r_quo        <= '0;
            r_div        <= '0;
            r_ge         <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid_i) begin
                        r_op  <= mdu_op_e'(req_op_i);
                        r_cnt <= '0;
                        case (mdu_op_e'(req_op_i))
                            MUL: begin
                                r_acc    <= '0;
                                r_mcand  <= req_a_i;
                                r_mplier <= req_b_i;
                                r_state  <= MUL_ADD;
                            end
                            DIVU, REMU: begin
                                if (req_b_i == '0) begin
                                    // Divide by zero: RISC-V defined results.
                                    r_resp_data <= (mdu_op_e'(req_op_i) == DIVU) ? '1 : req_a_i;
                                    r_state     <= DONE;
                                end else begin
                                    r_rem   <= '0;
                                    r_quo   <= req_a_i;
                                    r_div   <= req_b_i;
                                    r_state <= DIV_CMP;
                                end
                            end
                            default: begin
                                r_resp_data <= '0;
                                r_state     <= DONE;
                            end
                        endcase
                    end
                end
                MUL_ADD: begin
                    if (r_mplier[0]) begin
                        r_acc <= alu_res_i;
                    end
                    r_state <= MUL_SHIFT;
                end
                MUL_SHIFT: begin
                    r_mcand  <= alu_res_i;
                    r_mplier <= r_mplier >> 1;
                    if (w_last) begin
                        r_resp_data <= r_acc;
                        r_state     <= DONE;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= MUL_ADD;
                    end
                end
                DIV_CMP: begin
                    // The bit shifted out of the remainder is the 33rd bit of
                    // the true partial remainder; if set, it exceeds any divisor
                    // even though the 32-bit SLTU says "less".
                    r_ge    <= r_rem[XLEN-1] | ~alu_res_i[0];
                    r_rem   <= w_t;
                    r_quo   <= r_quo << 1;
                    r_state <= DIV_SUB;
                end
                DIV_SUB: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    if (w_last) begin
                        r_resp_data <= (r_op == REMU) ? w_rem_nxt : w_quo_nxt;
                        r_state     <= DONE;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= DIV_CMP;
                    end
                end
                DONE: begin
                    // Valid is raised one cycle after entering DONE, then the
                    // handshake returns to IDLE.
                    if (!r_resp_valid) begin
                        r_resp_valid <= 1'b1;
                    end else if (resp_ready_i) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu_sequencer.sv
// Self-checking bench for alu_mdu_sequencer: directed vector table, random
// operations against an arithmetic reference, and handshake/reset sequences.
module tb_alu_mdu_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_op_i;
    logic [31:0] req_a_i;
    logic [31:0] req_b_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_data_o;
    logic        busy_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic [3:0]  alu_sel_o;
    logic [31:0] alu_res_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    alu_mdu_sequencer #(.XLEN(32), .CNT_W(5)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_data_o  (resp_data_o),
        .busy_o       (busy_o),
        .alu_a_o      (alu_a_o),
        .alu_b_o      (alu_b_o),
        .alu_sel_o    (alu_sel_o),
        .alu_res_i    (alu_res_i)
    );

    // Shared integer ALU owned by the parent.
    always_comb begin
        case (alu_sel_o)
            4'b0000: alu_res_i = alu_a_o + alu_b_o;
            4'b0001: alu_res_i = alu_a_o << alu_b_o[4:0];
            4'b0011: alu_res_i = {31'b0, (alu_a_o < alu_b_o)};
            4'b1100: alu_res_i = alu_a_o - alu_b_o;
            4'b1111: alu_res_i = alu_b_o;
            default: alu_res_i = 32'h0;
        endcase
    end

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: RV32M semantics from plain arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (op)
            2'b00: begin
                p = {32'b0, a} * {32'b0, b};
                return p[31:0];
            end
            2'b01: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] b);
        if (op == 2'b11) return 1;
        if (op != 2'b00 && b == 0) return 1;
        return 65;
    endfunction

    // Issue one request and wait for the response; checks latency, result,
    // and that the sequencer refuses requests while working.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int k;
        logic ready_seen;
        @(negedge clk_i);
        req_valid_i  = 1'b1;
        req_op_i     = op;
        req_a_i      = a;
        req_b_i      = b;
        resp_ready_i = 1'b1;
        @(posedge clk_i);          // acceptance edge T
        @(negedge clk_i);
        req_valid_i = 1'b0;
        req_a_i     = $urandom;
        req_b_i     = $urandom;
        req_op_i    = 2'($urandom_range(0, 3));
        k = 0;
        ready_seen = 1'b0;
        while (!resp_valid_o && k < 200) begin
            if (req_ready_o) ready_seen = 1'b1;
            @(negedge clk_i);
            k++;
        end
        chk({name, " latency"}, 32'(k), 32'(lat));
        chk({name, " result"}, resp_data_o, exp);
        chk({name, " ready_low"}, {31'b0, ready_seen | req_ready_o}, 32'h0);
        $display("op=%0d a=0x%08h b=0x%08h -> 0x%08h (exp 0x%08h) latency %0d", op, a, b, resp_data_o, exp, k);
        @(negedge clk_i);          // handshake completed at the edge in between
        chk({name, " released"}, {30'b0, resp_valid_o, req_ready_o}, 32'h1);
    endtask

    initial begin
        int k;
        logic [31:0] held;
        logic ok;

        vecs[0]  = '{"mul_7x6",      2'b00, 32'd7,          32'd6,          32'd42,         65};
        vecs[1]  = '{"mul_ffxff",    2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h1,          65};
        vecs[2]  = '{"mul_msbx2",    2'b00, 32'h8000_0000,  32'd2,          32'h0,          65};
        vecs[3]  = '{"divu_100_7",   2'b01, 32'd100,        32'd7,          32'd14,         65};
        vecs[4]  = '{"remu_100_7",   2'b10, 32'd100,        32'd7,          32'd2,          65};
        vecs[5]  = '{"divu_ff_1",    2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  65};
        vecs[6]  = '{"remu_5_9",     2'b10, 32'd5,          32'd9,          32'd5,          65};
        vecs[7]  = '{"divu_by0",     2'b01, 32'd123,        32'd0,          32'hFFFF_FFFF,  1};
        vecs[8]  = '{"remu_by0",     2'b10, 32'd123,        32'd0,          32'd123,        1};
        vecs[9]  = '{"rsvd",         2'b11, 32'd55,         32'd66,         32'h0,          1};
        vecs[10] = '{"divu_bigdiv",  2'b01, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          65};
        vecs[11] = '{"remu_bigdiv",  2'b10, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  65};

        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        req_op_i     = 2'b00;
        req_a_i      = 32'h0;
        req_b_i      = 32'h0;
        resp_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("reset_valid", {31'b0, resp_valid_o}, 32'h0);
        chk("reset_data",  resp_data_o, 32'h0);
        chk("reset_ready_busy", {30'b0, req_ready_o, busy_o}, 32'h2);
        chk("reset_alu", alu_a_o | alu_b_o | {28'b0, alu_sel_o}, 32'h0);
        rst_i = 1'b0;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // Randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            run_op("random", op, a, b, ref_result(op, a, b), ref_latency(op, b));
        end

        // Stall in DONE for 10 cycles, then check no same-cycle re-accept
        @(negedge clk_i);
        req_valid_i  = 1'b1;
        req_op_i     = 2'b00;
        req_a_i      = 32'd1000;
        req_b_i      = 32'd3;
        resp_ready_i = 1'b0;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        k = 0;
        while (!resp_valid_o && k < 200) begin
            @(negedge clk_i);
            k++;
        end
        chk("stall latency", 32'(k), 32'd65);
        held = resp_data_o;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk_i);
            if (!resp_valid_o || resp_data_o !== held) ok = 1'b0;
        end
        chk("stall stable", {31'b0, ok}, 32'h1);
        chk("stall data", held, 32'd3000);
        // Offer a new request in the same cycle as the response handshake.
        resp_ready_i = 1'b1;
        req_valid_i  = 1'b1;
        req_op_i     = 2'b01;
        req_a_i      = 32'd50;
        req_b_i      = 32'd0;
        chk("ready_low_in_done", {31'b0, req_ready_o}, 32'h0);
        @(negedge clk_i);          // handshake edge passed
        chk("idle_after_handshake", {30'b0, busy_o, req_ready_o}, 32'h1);
        @(negedge clk_i);          // request accepted at this edge
        req_valid_i = 1'b0;
        chk("accept_next_cycle", {31'b0, busy_o}, 32'h1);
        @(negedge clk_i);
        chk("followup_valid", {31'b0, resp_valid_o}, 32'h1);
        chk("followup_data", resp_data_o, 32'hFFFF_FFFF);
        @(negedge clk_i);
        $display("stall sequence: held 0x%08h for 10 cycles, follow-up accepted after handshake", held);

        // Reset in the middle of a divide
        req_valid_i = 1'b1;
        req_op_i    = 2'b01;
        req_a_i     = 32'd1_000_000;
        req_b_i     = 32'd7;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        repeat (30) @(negedge clk_i);
        chk("pre_reset_busy", {31'b0, busy_o}, 32'h1);
        #2 rst_i = 1'b1;
        #1;
        chk("abort_ready_busy", {30'b0, req_ready_o, busy_o}, 32'h2);
        chk("abort_valid_data", {31'b0, resp_valid_o} | resp_data_o, 32'h0);
        chk("abort_alu", alu_a_o | alu_b_o | {28'b0, alu_sel_o}, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        ok = 1'b1;
        repeat (70) begin
            @(negedge clk_i);
            if (resp_valid_o || busy_o) ok = 1'b0;
        end
        chk("no_response_after_abort", {31'b0, ok}, 32'h1);
        $display("reset abort: divide cancelled at cycle 30");
        run_op("mul_3x5_after_reset", 2'b00, 32'd3, 32'd5, 32'd15, 65);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
